// File: rtl/pixel_dispatcher.sv
// pixel_dispatcher: walks the screen in raster order, launches one Mandelbrot
// solver run per pixel (cr/ci in 4.23 signed fixed point), waits for the solver
// to finish, then offers the pixel (x, y, color) downstream over valid/ready.
// One pixel is in flight at a time.
//
// Build option: define COLOR_MAP_EN to map the iteration count through an
// 8-entry log2 palette; otherwise the color is the low COLOR_W bits of the count.
module pixel_dispatcher #(
    parameter int H_RES   = 640,
    parameter int V_RES   = 480,
    parameter int X_W     = 10,
    parameter int Y_W     = 9,
    parameter int COLOR_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [26:0]        cr_start,
    input  logic [26:0]        ci_start,
    input  logic [26:0]        step,
    input  logic [12:0]        max_iter,
    output logic               solver_reset,
    output logic [26:0]        solver_cr,
    output logic [26:0]        solver_ci,
    output logic [12:0]        solver_max_iter,
    input  logic [12:0]        solver_iter,
    input  logic               solver_done,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [X_W-1:0]     pix_x,
    output logic [Y_W-1:0]     pix_y,
    output logic [COLOR_W-1:0] pix_color,
    output logic               busy,
    output logic               frame_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_SETTLE,
        S_WAIT,
        S_EMIT,
        S_DONE
    } state_t;

    state_t              state_reg;
    logic                settle_cnt_reg;
    logic [X_W-1:0]      x_reg;
    logic [Y_W-1:0]      y_reg;
    logic [26:0]         cr_reg;
    logic [26:0]         ci_reg;
    logic [26:0]         cr_start_reg;
    logic [26:0]         step_reg;
    logic [12:0]         max_iter_reg;

    logic                solver_reset_reg;
    logic [26:0]         solver_cr_reg;
    logic [26:0]         solver_ci_reg;
    logic                pix_valid_reg;
    logic [X_W-1:0]      pix_x_reg;
    logic [Y_W-1:0]      pix_y_reg;
    logic [COLOR_W-1:0]  pix_color_reg;
    logic                busy_reg;
    logic                frame_done_reg;

    // Next raster position and the matching solver coordinates.
    logic                last_x;
    logic                last_y;
    logic [X_W-1:0]      x_next;
    logic [Y_W-1:0]      y_next;
    logic [26:0]         cr_next;
    logic [26:0]         ci_next;
    logic [COLOR_W-1:0]  color_next;

    assign solver_reset    = solver_reset_reg;
    assign solver_cr       = solver_cr_reg;
    assign solver_ci       = solver_ci_reg;
    assign solver_max_iter = max_iter_reg;
    assign pix_valid       = pix_valid_reg;
    assign pix_x           = pix_x_reg;
    assign pix_y           = pix_y_reg;
    assign pix_color       = pix_color_reg;
    assign busy            = busy_reg;
    assign frame_done      = frame_done_reg;

    assign last_x = (x_reg == X_W'(H_RES - 1));
    assign last_y = (y_reg == Y_W'(V_RES - 1));

    // Raster advance: step right along the line, or wrap to the next line
    // (cr back to the line start, ci one step down). Adds wrap modulo 2^27.
    always_comb begin
        x_next  = x_reg;
        y_next  = y_reg;
        cr_next = cr_reg;
        ci_next = ci_reg;
        if (!last_x) begin
            x_next  = x_reg + X_W'(1);
            cr_next = cr_reg + step_reg;
        end else begin
            x_next  = '0;
            y_next  = y_reg + Y_W'(1);
            cr_next = cr_start_reg;
            ci_next = ci_reg - step_reg;
        end
    end

`ifdef COLOR_MAP_EN
    // Leading-one detector: bit gi is flagged when it is set and nothing above it is.
    logic [12:0] lead_onehot;
    genvar gi;
    generate
        for (gi = 0; gi < 13; gi++) begin : g_lead
            if (gi == 12) begin : g_top
                assign lead_onehot[gi] = solver_iter[gi];
            end else begin : g_low
                assign lead_onehot[gi] = solver_iter[gi] & ~(|solver_iter[12:gi+1]);
            end
        end
    endgenerate

    logic [3:0] lead_pos;
    logic [2:0] palette_idx;
    logic [7:0] palette_val;

    // Encode the leading-one position, clamp it to the palette size, then look it up.
    always_comb begin
        lead_pos = 4'd0;
        for (int i = 0; i < 13; i++) begin
            if (lead_onehot[i]) begin
                lead_pos = 4'(i);
            end
        end
        palette_idx = (lead_pos > 4'd7) ? 3'd7 : lead_pos[2:0];
        case (palette_idx)
            3'd0:    palette_val = 8'h03;
            3'd1:    palette_val = 8'h07;
            3'd2:    palette_val = 8'h0F;
            3'd3:    palette_val = 8'h1F;
            3'd4:    palette_val = 8'h3F;
            3'd5:    palette_val = 8'h7F;
            3'd6:    palette_val = 8'hBF;
            default: palette_val = 8'hFF;
        endcase
        if (solver_iter >= max_iter_reg) begin
            color_next = '0;
        end else begin
            color_next = COLOR_W'(palette_val);
        end
    end
`else
    // Points that never escaped are drawn black; the rest show the raw count.
    always_comb begin
        if (solver_iter >= max_iter_reg) begin
            color_next = '0;
        end else begin
            color_next = COLOR_W'(solver_iter);
        end
    end
`endif

    // Per-pixel sequencer. The solver's done flag lags its reset by two cycles,
    // so SETTLE waits that out before WAIT trusts solver_done again.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= S_IDLE;
            settle_cnt_reg   <= 1'b0;
            x_reg            <= '0;
            y_reg            <= '0;
            cr_reg           <= '0;
            ci_reg           <= '0;
            cr_start_reg     <= '0;
            step_reg         <= '0;
            max_iter_reg     <= '0;
            solver_reset_reg <= 1'b1;
            solver_cr_reg    <= '0;
            solver_ci_reg    <= '0;
            pix_valid_reg    <= 1'b0;
            pix_x_reg        <= '0;
            pix_y_reg        <= '0;
            pix_color_reg    <= '0;
            busy_reg         <= 1'b0;
            frame_done_reg   <= 1'b0;
        end else begin
            frame_done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    solver_reset_reg <= 1'b1;
                    if (start) begin
                        cr_start_reg  <= cr_start;
                        step_reg      <= step;
                        max_iter_reg  <= max_iter;
                        x_reg         <= '0;
                        y_reg         <= '0;
                        cr_reg        <= cr_start;
                        ci_reg        <= ci_start;
                        solver_cr_reg <= cr_start;
                        solver_ci_reg <= ci_start;
                        busy_reg      <= 1'b1;
                        state_reg     <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    solver_reset_reg <= 1'b0;
                    settle_cnt_reg   <= 1'b0;
                    state_reg        <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (settle_cnt_reg) begin
                        state_reg <= S_WAIT;
                    end else begin
                        settle_cnt_reg <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (solver_done) begin
                        pix_color_reg <= color_next;
                        pix_x_reg     <= x_reg;
                        pix_y_reg     <= y_reg;
                        pix_valid_reg <= 1'b1;
                        state_reg     <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (pix_ready) begin
                        pix_valid_reg    <= 1'b0;
                        solver_reset_reg <= 1'b1;
                        if (last_x && last_y) begin
                            frame_done_reg <= 1'b1;
                            busy_reg       <= 1'b0;
                            state_reg      <= S_DONE;
                        end else begin
                            x_reg         <= x_next;
                            y_reg         <= y_next;
                            cr_reg        <= cr_next;
                            ci_reg        <= ci_next;
                            solver_cr_reg <= cr_next;
                            solver_ci_reg <= ci_next;
                            state_reg     <= S_LAUNCH;
                        end
                    end
                end
                S_DONE: begin
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_dispatcher.sv
// Bench for pixel_dispatcher on a 4x2 screen: a registered solver model with
// per-pixel done delay and iteration tables, a reference model that computes
// each pixel's coordinates and color arithmetically, and directed frames.
module tb_pixel_dispatcher;

    localparam int H = 4;
    localparam int V = 2;
    localparam int NPIX = H * V;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [26:0] cr_start = '0;
    logic [26:0] ci_start = '0;
    logic [26:0] step = '0;
    logic [12:0] max_iter = '0;
    logic        solver_reset;
    logic [26:0] solver_cr;
    logic [26:0] solver_ci;
    logic [12:0] solver_max_iter;
    logic [12:0] solver_iter;
    logic        solver_done;
    logic        pix_valid;
    logic        pix_ready = 1'b1;
    logic [1:0]  pix_x;
    logic [0:0]  pix_y;
    logic [7:0]  pix_color;
    logic        busy;
    logic        frame_done;

    pixel_dispatcher #(.H_RES(H), .V_RES(V), .X_W(2), .Y_W(1), .COLOR_W(8)) dut (
        .clk(clk), .reset(reset), .start(start),
        .cr_start(cr_start), .ci_start(ci_start), .step(step), .max_iter(max_iter),
        .solver_reset(solver_reset), .solver_cr(solver_cr), .solver_ci(solver_ci),
        .solver_max_iter(solver_max_iter), .solver_iter(solver_iter),
        .solver_done(solver_done), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Stimulus tables for the solver model, indexed by pixel number.
    int iter_tab [NPIX];
    int dly_tab  [NPIX] = '{0, 3, 1, 5, 0, 2, 7, 1};

    // Reference model state.
    int          acc_cnt = 0;
    int          fd_cnt = 0;
    bit          frame_on = 0;
    bit          done_due = 0;
    bit          hold_prev = 0;
    logic [1:0]  prev_x = '0;
    logic [0:0]  prev_y = '0;
    logic [7:0]  prev_color = '0;
    logic [26:0] e_crs, e_cis, e_step;
    logic [12:0] e_max;
    logic [26:0] cap_cr [NPIX];
    logic [26:0] cap_ci [NPIX];
    logic [7:0]  cap_color [NPIX];
    int          cap_x [NPIX];
    int          cap_y [NPIX];

    function automatic logic [26:0] exp_cr(input int k);
        return e_crs + 27'(k % H) * e_step;
    endfunction

    function automatic logic [26:0] exp_ci(input int k);
        return e_cis - 27'(k / H) * e_step;
    endfunction

    function automatic logic [7:0] exp_color(input int it, input logic [12:0] mx);
        logic [7:0] pal [8] = '{8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hBF, 8'hFF};
        int p;
        if (it >= int'(mx)) return 8'h00;
`ifdef COLOR_MAP_EN
        p = (it == 0) ? 0 : $clog2(it + 1) - 1;
        if (p > 7) p = 7;
        return pal[p];
`else
        p = it % 256;
        return 8'(p);
`endif
    endfunction

    // Solver model: done clears two cycles after its reset is seen, then rises
    // dly_tab[k] cycles later carrying iter_tab[k] for the current pixel k.
    logic rst_d1 = 1'b1, rst_d2 = 1'b1;
    logic s_done = 1'b0;
    logic [12:0] s_iter = '0;
    int   s_cnt = 0;
    assign solver_done = s_done;
    assign solver_iter = s_iter;

    always @(posedge clk) begin
        rst_d1 <= solver_reset;
        rst_d2 <= rst_d1;
        if (rst_d2) begin
            s_cnt  <= 0;
            s_done <= 1'b0;
        end else if (!s_done && acc_cnt < NPIX) begin
            if (s_cnt >= dly_tab[acc_cnt]) begin
                s_done <= 1'b1;
                s_iter <= 13'(iter_tab[acc_cnt]);
            end else begin
                s_cnt <= s_cnt + 1;
            end
        end
    end

    // Compare process: every cycle, check the DUT against the reference model.
    always @(negedge clk) begin
        if (reset) begin
            acc_cnt   = 0;
            frame_on  = 0;
            done_due  = 0;
            hold_prev = 0;
        end else begin
            if (frame_done) fd_cnt++;
            if (done_due) begin
                check("frame_done_pulse", 32'(frame_done), 1);
                check("busy_at_done", 32'(busy), 0);
                check("valid_at_done", 32'(pix_valid), 0);
                done_due = 0;
                frame_on = 0;
            end else begin
                check("frame_done_quiet", 32'(frame_done), 0);
                check("busy", 32'(busy), 32'(frame_on));
                if (frame_on) begin
                    check("solver_cr", 32'(solver_cr), 32'(exp_cr(acc_cnt)));
                    check("solver_ci", 32'(solver_ci), 32'(exp_ci(acc_cnt)));
                    check("solver_max_iter", 32'(solver_max_iter), 32'(e_max));
                end else begin
                    check("valid_idle", 32'(pix_valid), 0);
                end
                if (hold_prev) begin
                    check("valid_hold", 32'(pix_valid), 1);
                    check("x_hold", 32'(pix_x), 32'(prev_x));
                    check("y_hold", 32'(pix_y), 32'(prev_y));
                    check("color_hold", 32'(pix_color), 32'(prev_color));
                end
                if (pix_valid && frame_on) begin
                    check("pix_x", 32'(pix_x), acc_cnt % H);
                    check("pix_y", 32'(pix_y), acc_cnt / H);
                    check("pix_color", 32'(pix_color), 32'(exp_color(iter_tab[acc_cnt], e_max)));
                    if (pix_ready) begin
                        cap_cr[acc_cnt]    = solver_cr;
                        cap_ci[acc_cnt]    = solver_ci;
                        cap_color[acc_cnt] = pix_color;
                        cap_x[acc_cnt]     = int'(pix_x);
                        cap_y[acc_cnt]     = int'(pix_y);
                        $display("pixel %0d: x=%0d y=%0d color=%0h cr=%0h ci=%0h",
                                 acc_cnt, pix_x, pix_y, pix_color, solver_cr, solver_ci);
                        acc_cnt++;
                        if (acc_cnt == NPIX) done_due = 1;
                    end
                end
                hold_prev  = pix_valid && !pix_ready;
                prev_x     = pix_x;
                prev_y     = pix_y;
                prev_color = pix_color;
                if (start && !busy && !frame_on) begin
                    e_crs    = cr_start;
                    e_cis    = ci_start;
                    e_step   = step;
                    e_max    = max_iter;
                    acc_cnt  = 0;
                    frame_on = 1;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_acc(input int n, input int budget);
        int c = 0;
        while (acc_cnt < n && c < budget) begin
            tick(1);
            c++;
        end
        if (acc_cnt < n) check("wait_acc_timeout", 32'(acc_cnt), 32'(n));
    endtask

    task automatic wait_frame(input int budget);
        int c = 0;
        while (!frame_done && c < budget) begin
            tick(1);
            c++;
        end
        check("frame_done_seen", 32'(frame_done), 1);
        tick(2);
    endtask

    task automatic wait_valid(input int budget);
        int c = 0;
        while (!pix_valid && c < budget) begin
            tick(1);
            c++;
        end
        check("valid_seen", 32'(pix_valid), 1);
    endtask

    initial begin
        iter_tab = '{5, 100, 37, 0, 99, 120, 1, 64};

        // Reset held 3 cycles with start asserted: must be ignored.
        reset = 1'b1;
        start = 1'b1;
        tick(3);
        check("rst_solver_reset", 32'(solver_reset), 1);
        check("rst_pix_valid", 32'(pix_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        check("rst_pix_xy", {pix_x, pix_y}, 0);
        check("rst_pix_color", 32'(pix_color), 0);
        check("rst_solver_cr", 32'(solver_cr), 0);
        check("rst_solver_ci", 32'(solver_ci), 0);
        reset = 1'b0;
        start = 1'b0;
        tick(3);
        check("idle_after_reset_busy", 32'(busy), 0);

        // Frame 1: -2.0 + 1.0i, step 0.5, max_iter 100.
        cr_start = 27'h7000000;
        ci_start = 27'h0800000;
        step     = 27'h0400000;
        max_iter = 13'd100;
        pulse_start();
        check("busy_after_start", 32'(busy), 1);
        check("launch_solver_reset", 32'(solver_reset), 1);
        // Changed inputs plus a stray start mid-frame must not disturb the frame.
        cr_start = 27'h1234567;
        step     = 27'h0000001;
        max_iter = 13'd7;
        pulse_start();
        wait_acc(2, 200);
        pix_ready = 1'b0;
        wait_valid(200);
        tick(5);
        check("stall_valid", 32'(pix_valid), 1);
        check("stall_no_accept", 32'(acc_cnt), 2);
        pix_ready = 1'b1;
        wait_frame(500);
        check("f1_pixels", 32'(acc_cnt), NPIX);
        check("f1_done_pulses", 32'(fd_cnt), 1);
        check("f1_cr_3_0", 32'(cap_cr[3]), 32'h7C00000);
        check("f1_cr_0_1", 32'(cap_cr[4]), 32'h7000000);
        check("f1_ci_0_1", 32'(cap_ci[4]), 32'h0400000);
        check("f1_last_xy", cap_x[7] * 10 + cap_y[7], 31);
        check("f1_color_at_max", 32'(cap_color[1]), 0);
`ifndef COLOR_MAP_EN
        check("f1_color_37", 32'(cap_color[2]), 37);
`endif

        // Frame 2: coordinates wrap around 2^27; aborted by reset in WAIT of (2,1).
        iter_tab = '{300, 17, 4000, 3999, 256, 255, 1, 42};
        cr_start = 27'h3FFFFF0;
        ci_start = 27'h4000000;
        step     = 27'h0000020;
        max_iter = 13'd4000;
        pulse_start();
        wait_acc(6, 400);
        tick(5);
        reset = 1'b1;
        tick(2);
        check("abort_busy", 32'(busy), 0);
        check("abort_valid", 32'(pix_valid), 0);
        check("abort_solver_reset", 32'(solver_reset), 1);
        check("abort_pix_xy", {pix_x, pix_y}, 0);
        reset = 1'b0;
        tick(3);
        check("abort_no_frame_done", 32'(fd_cnt), 1);

        // Frame 3: same settings, must run a full frame from (0,0).
        pulse_start();
        wait_frame(500);
        check("f3_pixels", 32'(acc_cnt), NPIX);
        check("f3_done_pulses", 32'(fd_cnt), 2);
        check("f3_cr_1_0_wrap", 32'(cap_cr[1]), 32'h4000010);
        check("f3_ci_row1_wrap", 32'(cap_ci[4]), 32'h3FFFFE0);
`ifndef COLOR_MAP_EN
        check("f3_color_300", 32'(cap_color[0]), 44);
`endif
        check("f3_idle_busy", 32'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute safety net against a hang.
    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
